// File: rtl/dsdmnist_seqctrl.sv
// dsdmnist_seqctrl: debounced start qualification and per-image sequencing of the MNIST inference core.
// Build macro DSDMNIST_SEQ_TIMEOUT_EN adds a WAIT watchdog that substitutes digit 4'hF on expiry.
module dsdmnist_seqctrl #(
    parameter int IMGNUM = 10,
    parameter int DBCYC  = 8,
    parameter int INTLEN = 16,
    parameter int IDXW   = (IMGNUM > 1) ? $clog2(IMGNUM) : 1
) (
    input  logic            i_CLK,
    input  logic            i_RST_n,
    input  logic            i_STARTSW,
    output logic            o_CORE_START,
    output logic [IDXW-1:0] o_CORE_IMGIDX,
    input  logic            i_CORE_DONE,
    input  logic [3:0]      i_CORE_RESULT,
    output logic            o_RESULTBUF_EN,
    output logic            o_RESULTBUF_WE,
    output logic [7:0]      o_RESULTBUF_DATA,
    output logic [IDXW-1:0] o_RESULTBUF_ADDR,
    output logic            o_ARMINT,
    output logic            o_DONELED
);
    // state | meaning
    // IDLE  | waiting for the first accepted press
    // START | one-cycle start pulse to the core
    // WAIT  | core busy, index held
    // WRITE | one-cycle result buffer write
    // NEXT  | advance index or finish the run
    // DONE  | run complete, LED lit, restartable
    typedef enum logic [2:0] {IDLE, START, WAIT, WRITE, NEXT, DONE} state_t;

    localparam logic [15:0]     DB_TC    = 16'(DBCYC);
    localparam logic [7:0]      INT_TC   = 8'(INTLEN);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(IMGNUM - 1);

    state_t          state;
    state_t          state_nxt;
    logic            sync1;
    logic            sync2;
    logic [15:0]     db_cnt;
    logic            press;
    logic [IDXW-1:0] idx;
    logic [3:0]      digit;
    logic            done_led;
    logic [7:0]      int_cnt;
    logic            wd_hit;
    logic            core_hit;
    logic [3:0]      hit_digit;

    // Counter saturates at DB_TC, so a held switch yields a single press pulse.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= i_STARTSW;
            sync2 <= sync1;
            press <= sync2 && (db_cnt == DB_TC - 16'd1);
            if (!sync2)
                db_cnt <= '0;
            else if (db_cnt != DB_TC)
                db_cnt <= db_cnt + 16'd1;
        end
    end

`ifdef DSDMNIST_SEQ_TIMEOUT_EN
    logic [19:0] wd_cnt;

    // Down-counter armed in START; expiry after 20'hFFFFF cycles without a done.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_n)
            wd_cnt <= 20'hFFFFF;
        else if (state == START)
            wd_cnt <= 20'hFFFFF;
        else if (state == WAIT && !i_CORE_DONE && wd_cnt != 20'd0)
            wd_cnt <= wd_cnt - 20'd1;
    end

    assign wd_hit = (state == WAIT) && (wd_cnt == 20'd0);
`else
    assign wd_hit = 1'b0;
`endif

    assign core_hit  = (state == WAIT) && (i_CORE_DONE || wd_hit);
    assign hit_digit = i_CORE_DONE ? i_CORE_RESULT : 4'hF;

    always_ff @(posedge i_CLK) begin
        if (!i_RST_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (press) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (core_hit) state_nxt = WRITE;
            WRITE:   state_nxt = NEXT;
            NEXT:    state_nxt = (idx == LAST_IDX) ? DONE : START;
            DONE:    if (press) state_nxt = START;
            default: state_nxt = IDLE;
        endcase
    end

    // The interrupt timer is only reloaded at run completion, so a restart never truncates it.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            idx      <= '0;
            digit    <= 4'h0;
            done_led <= 1'b0;
            int_cnt  <= 8'd0;
        end else begin
            if (int_cnt != 8'd0)
                int_cnt <= int_cnt - 8'd1;
            case (state)
                IDLE: if (press) idx <= '0;
                DONE: if (press) begin
                    idx      <= '0;
                    done_led <= 1'b0;
                end
                WAIT: if (core_hit) digit <= hit_digit;
                NEXT: if (idx == LAST_IDX) begin
                    done_led <= 1'b1;
                    int_cnt  <= INT_TC;
                end else begin
                    idx <= idx + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_CORE_START     = (state == START);
        o_CORE_IMGIDX    = idx;
        o_RESULTBUF_EN   = (state == WRITE);
        o_RESULTBUF_WE   = (state == WRITE);
        o_RESULTBUF_DATA = (state == WRITE) ? {4'h0, digit} : 8'h00;
        o_RESULTBUF_ADDR = (state == WRITE) ? idx : '0;
        o_ARMINT         = (int_cnt != 8'd0);
        o_DONELED        = done_led;
    end
endmodule
